// File: rtl/fir_sample_capture_if.sv
// Control, capture and playback signals of fir_sample_capture.
// master drives the requests; slave is the capture block.
interface fir_sample_capture_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              abort;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              rd_ready;

  modport master (
    output start, abort, sample_in, sample_valid, rd_ready,
    input  busy, done, count, rd_data, rd_valid, rd_last
  );

  modport slave (
    input  start, abort, sample_in, sample_valid, rd_ready,
    output busy, done, count, rd_data, rd_valid, rd_last
  );
endinterface

// File: rtl/fir_sample_capture.sv
// Records DEPTH valid FIR output samples after a start pulse,
// then replays them in order on a valid/ready stream.
module fir_sample_capture #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 400,
  parameter int CNT_W  = 16
) (
  input logic                 clk,
  input logic                 rst,
  fir_sample_capture_if.slave bus
);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mem_q;
  logic              mem_vld;
  logic              mem_last;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              busy;
  logic              done;

  logic go;
  logic wr_en;
  logic wr_final;
  logic xfer_last;
  logic out_load;
  logic rd_issue;

  always_comb begin
    go = (state == IDLE) && bus.start && !bus.abort;
    wr_en = (state == CAPTURE) && bus.sample_valid
         && !bus.abort;
    wr_final = wr_en && (wr_ptr == LAST);
    xfer_last = (state == DRAIN) && rd_valid
             && bus.rd_ready && rd_last && !bus.abort;
    out_load = (state == DRAIN)
            && (!rd_valid || bus.rd_ready);
    // fetch only when the read register will be free next edge
    rd_issue = (state == DRAIN) && (rd_ptr != FULL)
            && (!mem_vld || out_load);
  end

  always_comb begin
    state_next = state;
    unique case (1'b1)
      bus.abort: state_next = IDLE;
      go:        state_next = CAPTURE;
      wr_final:  state_next = DRAIN;
      xfer_last: state_next = IDLE;
      default:   state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == CAPTURE)
            || (state_next == DRAIN);
      done  <= xfer_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (go) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      count  <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= bus.sample_in;
  end

  always_ff @(posedge clk) begin
    if (rd_issue) mem_q <= mem[rd_ptr[AW-1:0]];
  end

  // two-stage playback: memory read register, then output register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      mem_vld  <= 1'b0;
      mem_last <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else if (state_next != DRAIN) begin
      rd_ptr   <= '0;
      mem_vld  <= 1'b0;
      mem_last <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      if (rd_issue) begin
        rd_ptr   <= rd_ptr + 1'b1;
        mem_vld  <= 1'b1;
        mem_last <= (rd_ptr == LAST);
      end else if (out_load) begin
        mem_vld  <= 1'b0;
      end
      if (out_load) begin
        rd_valid <= mem_vld;
        rd_last  <= mem_vld && mem_last;
        if (mem_vld) rd_data <= mem_q;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.count    = count;
  assign bus.rd_data  = rd_data;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_last  = rd_last;
endmodule

// File: tb/tb_fir_sample_capture.sv
// Randomized bench for fir_sample_capture with a queue-based
// model: a capture is the first D valid samples after start.
module tb_fir_sample_capture;
  localparam int DW = 8;
  localparam int D  = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_sample_capture_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  fir_sample_capture #(
    .DATA_W(DW),
    .DEPTH (D),
    .CNT_W (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic idle_inputs();
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.rd_ready     = 1'b0;
  endtask

  task automatic capture(input int vpct, input int smode,
                         input int start_at,
                         input int abort_at);
    logic [DW-1:0] pat [4];
    logic [DW-1:0] v;
    logic vld;
    int mc;
    int cyc;
    pat[0] = 8'h80; pat[1] = 8'hFF;
    pat[2] = 8'h7F; pat[3] = 8'h00;
    mc = 0;
    cyc = 0;
    exp_q.delete();
    bus.start = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_in = DW'($urandom);
    step();
    bus.start = 1'b0;
    chk("cap_busy_start", bus.busy, 1);
    while (mc < D && cyc < 200) begin
      chk("cap_count", bus.count, mc);
      chk("cap_busy", bus.busy, 1);
      chk("cap_rd_valid", bus.rd_valid, 0);
      if (mc == abort_at) begin
        bus.abort = 1'b1;
        bus.sample_valid = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.sample_valid = 1'b0;
        chk("abort_cap_busy", bus.busy, 0);
        chk("abort_cap_count", bus.count, abort_at);
        for (int i = 0; i < 3; i++) begin
          step();
          chk("abort_cap_done", bus.done, 0);
          chk("abort_cap_hold", bus.count, abort_at);
        end
        return;
      end
      bus.start = (cyc == start_at);
      vld = ($urandom_range(99) < vpct);
      if (smode == 0) v = DW'(mc + 1);
      else if (smode == 1 && mc < 4) v = pat[mc];
      else v = DW'($urandom);
      bus.sample_valid = vld;
      bus.sample_in = v;
      if (vld) begin
        exp_q.push_back(v);
        mc++;
      end
      step();
      cyc++;
    end
    bus.sample_valid = 1'b0;
    bus.start = 1'b0;
    chk("cap_timeout", (mc == D), 1);
    chk("cap_count_full", bus.count, D);
    chk("cap_busy_drain", bus.busy, 1);
  endtask

  task automatic drain(input int rmode, input int abort_after);
    int idx = 0;
    int cyc = 0;
    int first = -1;
    int first_x = -1;
    int last_x = -1;
    bit held = 0;
    bit fin = 0;
    bit rdy;
    logic [DW-1:0] hd;
    logic hl;
    while (!fin && cyc < 200) begin
      chk("drn_done", bus.done, 0);
      chk("drn_count", bus.count, D);
      if (bus.rd_valid && first < 0) first = cyc;
      if (held) begin
        chk("stall_valid", bus.rd_valid, 1);
        chk("stall_data", bus.rd_data, hd);
        chk("stall_last", bus.rd_last, hl);
      end
      if (abort_after > 0 && idx == abort_after) begin
        bus.abort = 1'b1;
        bus.rd_ready = 1'b0;
        step();
        bus.abort = 1'b0;
        chk("abort_drn_busy", bus.busy, 0);
        chk("abort_drn_valid", bus.rd_valid, 0);
        chk("abort_drn_last", bus.rd_last, 0);
        chk("abort_drn_count", bus.count, D);
        for (int i = 0; i < 3; i++) begin
          step();
          chk("abort_drn_done", bus.done, 0);
        end
        exp_q.delete();
        return;
      end
      case (rmode)
        1: rdy = (cyc % 2 == 0);
        2: rdy = (cyc >= 4 && cyc < 9) ? 1'b0
               : 1'($urandom_range(1));
        default: rdy = 1'b1;
      endcase
      bus.rd_ready = rdy;
      bus.start = (rmode == 3 && idx == 1);
      bus.sample_valid = 1'($urandom);
      bus.sample_in = DW'($urandom);
      if (bus.rd_valid && rdy) begin
        chk("rd_data", bus.rd_data, exp_q[0]);
        chk("rd_last", bus.rd_last, (idx == D - 1));
        void'(exp_q.pop_front());
        if (idx == 0) first_x = cyc;
        last_x = cyc;
        idx++;
        held = 0;
        if (idx == D) fin = 1;
      end else begin
        held = bus.rd_valid;
        hd = bus.rd_data;
        hl = bus.rd_last;
      end
      step();
      cyc++;
    end
    bus.start = 1'b0;
    bus.sample_valid = 1'b0;
    chk("drn_timeout", fin, 1);
    chk("done_pulse", bus.done, 1);
    chk("done_rd_valid", bus.rd_valid, 0);
    chk("done_busy", bus.busy, 0);
    if (rmode == 0) begin
      chk("first_valid_lat", (first >= 0 && first <= 2), 1);
      chk("b2b_rate", last_x - first_x, D - 1);
    end
  endtask

  task automatic after_done();
    bus.rd_ready = 1'b0;
    step();
    chk("done_one_cycle", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'($urandom);
      bus.abort = 1'($urandom);
      bus.sample_valid = 1'($urandom);
      bus.sample_in = DW'($urandom);
      bus.rd_ready = 1'($urandom);
      step();
    end
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_last", bus.rd_last, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    idle_inputs();
    rst = 1'b0;
    step();
    chk("post_rst_busy", bus.busy, 0);
  endtask

  task automatic test_basic();
    capture(100, 0, -1, -1);
    drain(0, 0);
    after_done();
  endtask

  task automatic test_gaps_signs();
    capture(50, 1, -1, -1);
    drain(0, 0);
    after_done();
  endtask

  task automatic test_backpressure();
    capture(80, 2, -1, -1);
    drain(1, 0);
    after_done();
    capture(60, 2, -1, -1);
    drain(2, 0);
    after_done();
  endtask

  task automatic test_abort();
    capture(70, 2, -1, 3);
    capture(100, 2, -1, -1);
    drain(0, 2);
    capture(50, 1, -1, -1);
    drain(0, 0);
    after_done();
  endtask

  task automatic test_ignored_start();
    capture(70, 2, 2, -1);
    drain(3, 0);
    after_done();
  endtask

  task automatic test_back_to_back();
    capture(100, 2, -1, -1);
    drain(0, 0);
    capture(90, 2, -1, -1);
    drain(1, 0);
    after_done();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_gaps_signs();
    test_backpressure();
    test_abort();
    test_ignored_start();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
